free_list_mp: RTL and testbench
===============================

FREE_LIST_MP -- requirements
Module: free_list_mp

Interface
REQ-001 Parameter NUM_PHYS, default 64: physical register count and queue depth; SHALL be a power of two, at least 8.
REQ-002 Parameter RESV, default 1: phys 0..RESV-1 are never free; the free list SHALL NOT hold them after reset.
REQ-003 Parameter ALLOC_W, default 2: allocation lanes per cycle.
REQ-004 Parameter FREE_W, default 2: free lanes per cycle.
REQ-005 Parameter NUM_CKPT, default 4: head-pointer checkpoint slots.
REQ-006 Localparams SHALL be PIDX_W=$clog2(NUM_PHYS), PTR_W=PIDX_W+1 and CK_W=$clog2(NUM_CKPT).
REQ-007 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-008 Port rst, input, 1: reset, asynchronous and active-high.
REQ-009 Port alloc_req_cnt, input, $clog2(ALLOC_W+1): number of registers requested this cycle, lanes 0..cnt-1.
REQ-010 Port alloc_grant, output, 1: all requested lanes granted this cycle.
REQ-011 Port alloc_phys[ALLOC_W], output, PIDX_W each: lane i SHALL equal queue[head+i], combinational.
REQ-012 Port free_en[FREE_W], input, 1 each: lane valid.
REQ-013 Port free_phys[FREE_W], input, PIDX_W each: register returned at commit.
REQ-014 Port ckpt_save, input, 1, together with ckpt_save_id, input, CK_W: save the head into a slot.
REQ-015 Port ckpt_restore, input, 1, together with ckpt_restore_id, input, CK_W: mispredict recovery.
REQ-016 Port free_count, output, PTR_W: equals tail-head.
REQ-017 Port err, output, 1: sticky error flag.

Function
REQ-018 Queue SHALL be circular, NUM_PHYS entries; head and tail SHALL be PTR_W-bit pointers with a wrap bit; indexing SHALL use the low PIDX_W bits.
REQ-019 alloc_grant SHALL be 1 when alloc_req_cnt<=free_count and ckpt_restore=0; else 0.
REQ-020 Allocation SHALL be all-or-nothing: no partial grants.
REQ-021 On grant, head SHALL advance by alloc_req_cnt at the next edge; alloc_req_cnt=0 SHALL give grant=1 and no head change.
REQ-022 Valid free lanes SHALL be compacted in lane order and written at tail, tail+1, ...; tail SHALL advance by popcount(free_en).
REQ-023 Free lanes SHALL NOT bypass to allocation: a register freed in cycle N is allocatable in cycle N+1 at the earliest.
REQ-024 Simultaneous alloc and free SHALL both apply; free_count next = free_count + frees - granted.
REQ-025 ckpt_save SHALL store the post-allocation head of that cycle (head + granted count) into slot ckpt_save_id.
REQ-026 ckpt_restore SHALL set head to slot[ckpt_restore_id]; frees in the same cycle SHALL still apply; allocation SHALL be blocked that cycle.
REQ-027 Save and restore in the same cycle: restore SHALL win for head; the save SHALL write the restored head value.
REQ-028 err SHALL set, and stay set until reset, on any of:
- a free lane with phys<RESV (that lane's write suppressed);
- free_count + frees > NUM_PHYS-RESV (the whole cycle's frees suppressed);
- a restore whose resulting free_count would exceed NUM_PHYS-RESV (restore ignored).
REQ-029 Wrap-around: pointer arithmetic SHALL be modulo 2^PTR_W; full = (tail-head)==NUM_PHYS-RESV; empty = tail==head.

Reset
REQ-030 On rst SHALL set:
- queue[k] = RESV+k for k in 0..NUM_PHYS-RESV-1;
- head=0, tail=NUM_PHYS-RESV, err=0, all checkpoint slots=0.
REQ-031 Outputs during and right after reset SHALL be free_count=NUM_PHYS-RESV and alloc_phys[i]=RESV+i.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight state immediately, without waiting for an edge.

Structure
REQ-033 The phys_idx_t typedef and NUM_PHYS/RESV defaults SHALL live in the shared rename package, used by the rename unit and ROB.
REQ-034 One sub-module, free_list_ckpt_tbl, SHALL hold the NUM_CKPT x PTR_W head slots with one write port and one read port; there SHALL be no other hierarchy.

Verification (defaults)
REQ-035 Reset, then alloc_req_cnt=2 -> grant=1, alloc_phys={1,2}; next cycle free_count=61, alloc_phys={3,4}.
REQ-036 Drain to free_count=1, then request 2 -> grant=0, head unchanged; request 1 -> grant=1 giving phys 63, free_count=0.
REQ-037 Same cycle: alloc 2 plus free_en={1,1} phys {40,41} -> free_count unchanged; 40 and 41 are dequeued after the existing entries.
REQ-038 Save slot 2 at head=5, alloc 6 more, restore slot 2 -> head=5, grant=0 that cycle, free_count up by 6.
REQ-039 Free phys 0, or free when full -> err=1 and sticky, free_count unchanged; async rst pulse mid-cycle -> err=0 and free_count=63 with no clock edge.
REQ-040 Run 200 cycles of random alloc/free across the pointer wrap -> no duplicate allocation; the multiset of queue entries plus live registers always equals 1..63.

Source files
------------

// File: rtl/free_list_mp_pkg.sv
// Shared rename package: physical register index type and default
// physical register file sizing, used by the free list, rename and ROB.
package free_list_mp_pkg;

    localparam int NUM_PHYS_DEF = 64;
    localparam int RESV_DEF     = 1;
    localparam int PIDX_W_DEF   = $clog2(NUM_PHYS_DEF);

    typedef logic [PIDX_W_DEF-1:0] phys_idx_t;

endpackage

// File: rtl/free_list_ckpt_tbl.sv
// Checkpoint table of head pointers for branch recovery.
// Ports: we/waddr/wdata write port, raddr/rdata combinational read port.
module free_list_ckpt_tbl
    import free_list_mp_pkg::*;
#(
    parameter  int NUM_CKPT = 4,
    parameter  int PTR_W    = 7,
    localparam int CK_W     = $clog2(NUM_CKPT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [CK_W-1:0]  waddr,
    input  logic [PTR_W-1:0] wdata,
    input  logic [CK_W-1:0]  raddr,
    output logic [PTR_W-1:0] rdata
);

    logic [PTR_W-1:0] slot_q [NUM_CKPT];
    logic [PTR_W-1:0] slot_d [NUM_CKPT];

    always_comb begin
        slot_d = slot_q;
        if (we) begin
            slot_d[waddr] = wdata;
        end
    end

    assign rdata = slot_q[raddr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '{default: '0};
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/free_list_mp.sv
// Multi-port circular free list of physical registers with head checkpoints.
// Ports: alloc_req_cnt/alloc_grant/alloc_phys allocate, free_en/free_phys
// return at commit, ckpt_save*/ckpt_restore* recover, free_count, sticky err.
module free_list_mp
    import free_list_mp_pkg::*;
#(
    parameter  int NUM_PHYS = NUM_PHYS_DEF,
    parameter  int RESV     = RESV_DEF,
    parameter  int ALLOC_W  = 2,
    parameter  int FREE_W   = 2,
    parameter  int NUM_CKPT = 4,
    localparam int PIDX_W   = $clog2(NUM_PHYS),
    localparam int PTR_W    = PIDX_W + 1,
    localparam int CK_W     = $clog2(NUM_CKPT),
    localparam int CNT_W    = $clog2(ALLOC_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  alloc_req_cnt,
    output logic              alloc_grant,
    output logic [PIDX_W-1:0] alloc_phys [ALLOC_W],
    input  logic              free_en [FREE_W],
    input  logic [PIDX_W-1:0] free_phys [FREE_W],
    input  logic              ckpt_save,
    input  logic [CK_W-1:0]   ckpt_save_id,
    input  logic              ckpt_restore,
    input  logic [CK_W-1:0]   ckpt_restore_id,
    output logic [PTR_W-1:0]  free_count,
    output logic              err
);

    localparam logic [PTR_W-1:0] MAX_FREE = PTR_W'(NUM_PHYS - RESV);

    logic [PIDX_W-1:0] queue_q [NUM_PHYS];
    logic [PIDX_W-1:0] queue_d [NUM_PHYS];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic              err_q, err_d;

    logic [PTR_W-1:0]  avail;
    logic [PTR_W-1:0]  req_ext;
    logic [PTR_W-1:0]  granted;
    logic [PTR_W-1:0]  nfree;
    logic              lane_ok [FREE_W];
    logic              bad_phys;
    logic              free_ovf;
    logic [PTR_W-1:0]  rest_head;
    logic [PTR_W-1:0]  rest_cnt;
    logic              rest_ok;

    assign avail      = tail_q - head_q;
    assign free_count = avail;
    assign err        = err_q;

    always_comb begin
        for (int i = 0; i < ALLOC_W; i++) begin
            alloc_phys[i] = queue_q[PIDX_W'(head_q + PTR_W'(i))];
        end
    end

    // Restore steals the cycle, so the grant is withheld even if it fits.
    assign req_ext     = PTR_W'(alloc_req_cnt);
    assign alloc_grant = (req_ext <= avail) && !ckpt_restore;
    assign granted     = alloc_grant ? req_ext : '0;

    always_comb begin
        bad_phys = 1'b0;
        nfree    = '0;
        for (int i = 0; i < FREE_W; i++) begin
            lane_ok[i] = free_en[i] && (int'(free_phys[i]) >= RESV);
            bad_phys   = bad_phys | (free_en[i] && !lane_ok[i]);
            nfree      = nfree + PTR_W'(lane_ok[i]);
        end
        free_ovf = (avail + nfree) > MAX_FREE;
    end

    // Valid lanes are packed in lane order starting at tail.
    always_comb begin
        logic [PTR_W-1:0] wptr;
        queue_d = queue_q;
        wptr    = tail_q;
        for (int i = 0; i < FREE_W; i++) begin
            if (lane_ok[i] && !free_ovf) begin
                queue_d[PIDX_W'(wptr)] = free_phys[i];
                wptr = wptr + 1'b1;
            end
        end
    end

    assign tail_d = free_ovf ? tail_q : tail_q + nfree;

    // A stale checkpoint would claim more free entries than exist.
    assign rest_cnt = tail_d - rest_head;
    assign rest_ok  = ckpt_restore && (rest_cnt <= MAX_FREE);
    assign head_d   = rest_ok ? rest_head : head_q + granted;

    assign err_d = err_q | bad_phys | free_ovf
                 | (ckpt_restore && !rest_ok);

    // Save writes head_d, so a same-cycle restore value is captured.
    free_list_ckpt_tbl #(
        .NUM_CKPT (NUM_CKPT),
        .PTR_W    (PTR_W)
    ) u_ckpt (
        .clk   (clk),
        .rst   (rst),
        .we    (ckpt_save),
        .waddr (ckpt_save_id),
        .wdata (head_d),
        .raddr (ckpt_restore_id),
        .rdata (rest_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_PHYS; k++) begin
                if (k < NUM_PHYS - RESV) begin
                    queue_q[k] <= PIDX_W'(RESV + k);
                end else begin
                    queue_q[k] <= '0;
                end
            end
            head_q <= '0;
            tail_q <= MAX_FREE;
            err_q  <= 1'b0;
        end else begin
            queue_q <= queue_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_free_list_mp.sv
// Directed and randomized self-checking bench for free_list_mp.
// Drives inputs after the rising edge and samples one step later.
module tb_free_list_mp;

    localparam int AW = 2;
    localparam int FW = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] cnt;
    logic       grant;
    logic [5:0] aphys [AW];
    logic       fen [FW];
    logic [5:0] fphys [FW];
    logic       sv;
    logic [1:0] svid;
    logic       rs;
    logic [1:0] rsid;
    logic [6:0] fc;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    int fq[$];
    int live[$];

    always #5 clk = ~clk;

    free_list_mp dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req_cnt   (cnt),
        .alloc_grant     (grant),
        .alloc_phys      (aphys),
        .free_en         (fen),
        .free_phys       (fphys),
        .ckpt_save       (sv),
        .ckpt_save_id    (svid),
        .ckpt_restore    (rs),
        .ckpt_restore_id (rsid),
        .free_count      (fc),
        .err             (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic set(input int c, input int e0 = 0, input int p0 = 0,
                       input int e1 = 0, input int p1 = 0,
                       input int s = 0, input int sid = 0,
                       input int r = 0, input int rid = 0);
        cnt      = 2'(c);
        fen[0]   = (e0 != 0);
        fphys[0] = 6'(p0);
        fen[1]   = (e1 != 0);
        fphys[1] = 6'(p1);
        sv       = (s != 0);
        svid     = 2'(sid);
        rs       = (r != 0);
        rsid     = 2'(rid);
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int idx;
        int fe [FW];
        int fp [FW];
        bit g;

        set(0);
        rst = 1'b1;
        #1;
        chk("rst_fc", 32'(fc), 63);
        chk("rst_a0", 32'(aphys[0]), 1);
        chk("rst_a1", 32'(aphys[1]), 2);
        chk("rst_err", 32'(err), 0);
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("post_rst_fc", 32'(fc), 63);

        // basic allocation
        set(2);
        chk("a2_grant", 32'(grant), 1);
        chk("a2_a0", 32'(aphys[0]), 1);
        chk("a2_a1", 32'(aphys[1]), 2);
        tick;
        set(0);
        chk("a2_fc", 32'(fc), 61);
        chk("a2_next_a0", 32'(aphys[0]), 3);
        chk("a2_next_a1", 32'(aphys[1]), 4);

        // drain to one entry, all-or-nothing
        set(2);
        repeat (30) tick;
        set(0);
        chk("drain_fc", 32'(fc), 1);
        set(2);
        chk("short_grant", 32'(grant), 0);
        tick;
        set(0);
        chk("short_fc", 32'(fc), 1);
        chk("short_a0", 32'(aphys[0]), 63);
        set(1);
        chk("last_grant", 32'(grant), 1);
        chk("last_a0", 32'(aphys[0]), 63);
        tick;
        set(0);
        chk("empty_fc", 32'(fc), 0);
        chk("zero_req_grant", 32'(grant), 1);
        set(1);
        chk("empty_grant", 32'(grant), 0);

        // frees never bypass; compaction order
        set(1, 1, 10, 1, 11);
        chk("nobypass_grant", 32'(grant), 0);
        tick;
        set(0, 1, 12, 1, 13);
        tick;
        set(0);
        chk("free4_fc", 32'(fc), 4);
        chk("free4_a0", 32'(aphys[0]), 10);
        chk("free4_a1", 32'(aphys[1]), 11);
        set(2, 1, 40, 1, 41);
        chk("mix_grant", 32'(grant), 1);
        chk("mix_a0", 32'(aphys[0]), 10);
        chk("mix_a1", 32'(aphys[1]), 11);
        tick;
        set(0);
        chk("mix_fc", 32'(fc), 4);
        chk("mix_next_a0", 32'(aphys[0]), 12);
        chk("mix_next_a1", 32'(aphys[1]), 13);
        set(2);
        tick;
        set(0);
        chk("mix2_fc", 32'(fc), 2);
        chk("mix2_a0", 32'(aphys[0]), 40);
        chk("mix2_a1", 32'(aphys[1]), 41);

        // checkpoints
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        set(2);
        tick;
        tick;
        set(1, 0, 0, 0, 0, 1, 2);
        tick;
        set(2);
        tick;
        tick;
        tick;
        set(0);
        chk("ck_pre_fc", 32'(fc), 52);
        set(2, 0, 0, 0, 0, 1, 3, 1, 2);
        chk("ck_rest_grant", 32'(grant), 0);
        tick;
        set(0);
        chk("ck_rest_fc", 32'(fc), 58);
        chk("ck_rest_a0", 32'(aphys[0]), 6);
        set(2);
        tick;
        set(0, 0, 0, 0, 0, 0, 0, 1, 3);
        tick;
        set(0);
        chk("ck_save_rest_fc", 32'(fc), 58);
        chk("ck_save_rest_a0", 32'(aphys[0]), 6);
        set(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick;
        set(0);
        chk("ck_slot0_fc", 32'(fc), 63);
        chk("ck_slot0_a0", 32'(aphys[0]), 1);
        chk("ck_err", 32'(err), 0);

        // stale checkpoint restore is rejected
        set(2, 0, 0, 0, 0, 1, 1);
        tick;
        set(2);
        tick;
        set(0, 1, 1, 1, 2);
        tick;
        set(0, 1, 3);
        tick;
        set(0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("stale_grant", 32'(grant), 0);
        tick;
        set(0);
        chk("stale_err", 32'(err), 1);
        chk("stale_fc", 32'(fc), 62);
        chk("stale_a0", 32'(aphys[0]), 5);

        // asynchronous reset, no clock edge
        rst = 1'b1;
        #1;
        chk("arst_err", 32'(err), 0);
        chk("arst_fc", 32'(fc), 63);
        chk("arst_a0", 32'(aphys[0]), 1);
        chk("arst_a1", 32'(aphys[1]), 2);
        rst = 1'b0;
        #1;

        // reserved register freed
        set(2);
        tick;
        set(0, 1, 0, 1, 1);
        tick;
        set(0);
        chk("resv_err", 32'(err), 1);
        chk("resv_fc", 32'(fc), 62);
        tick;
        chk("resv_sticky", 32'(err), 1);

        // free when full
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        chk("full_pre_err", 32'(err), 0);
        set(0, 1, 9);
        tick;
        set(0);
        chk("full_err", 32'(err), 1);
        chk("full_fc", 32'(fc), 63);

        // random alloc/free across pointer wrap
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        fq.delete();
        live.delete();
        for (int k = 1; k <= 63; k++) fq.push_back(k);
        for (int n = 0; n < 200; n++) begin
            c = $urandom_range(0, 2);
            for (int i = 0; i < FW; i++) begin
                fe[i] = 0;
                fp[i] = 0;
                if (live.size() > 0 && $urandom_range(0, 1) == 1) begin
                    idx = $urandom_range(0, live.size() - 1);
                    fp[i] = live[idx];
                    live.delete(idx);
                    fe[i] = 1;
                end
            end
            set(c, fe[0], fp[0], fe[1], fp[1]);
            g = (c <= fq.size());
            chk("rnd_grant", 32'(grant), 32'(g));
            chk("rnd_fc", 32'(fc), fq.size());
            for (int i = 0; i < AW; i++) begin
                if (i < fq.size()) begin
                    chk("rnd_alloc", 32'(aphys[i]), fq[i]);
                end
            end
            tick;
            if (g) begin
                for (int i = 0; i < c; i++) live.push_back(fq.pop_front());
            end
            for (int i = 0; i < FW; i++) begin
                if (fe[i] != 0) fq.push_back(fp[i]);
            end
        end
        set(0);
        chk("rnd_end_fc", 32'(fc), fq.size());
        chk("rnd_end_err", 32'(err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
